// File: rtl/i2c_slave.sv
// I2C target endpoint: oversamples SCL/SDA, decodes START/STOP, matches a 7-bit
// address, ACKs written bytes and serves read bytes from a one-entry holding register.
module i2c_slave #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_WIDTH  = DATA_WIDTH - 1
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] self_addr_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic [DATA_WIDTH-1:0] status_o
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] BYTE_BITS = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_DATA,
    S_RX_ACK,
    S_TX_DATA,
    S_TX_ACK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;
  logic                   start_det;
  logic                   stop_det;
  logic                   scl_rise;
  logic                   scl_fall;
  logic [3:0]             bit_cnt;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  load_byte;
  logic                   ack_q;
  logic                   rx_pend;
  logic                   st_busy;
  logic                   st_match;
  logic                   st_dir;
  logic                   st_nack;
  logic                   st_underrun;

  // Bring the asynchronous bus lines into clk_i and keep one extra delayed copy for edges
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;

  // An empty holding register is answered with all ones (bus left released)
  assign load_byte = tx_valid_i ? tx_data_i : '1;

  assign status_o = {{(DATA_WIDTH-5){1'b0}}, st_underrun, st_nack, st_dir, st_match, st_busy};

  // Protocol FSM; every output is a flop so SDA only moves one cycle after a detected SCL fall
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      tx_shift    <= '0;
      ack_q       <= 1'b0;
      rx_pend     <= 1'b0;
      sda_o       <= 1'b1;
      tx_ready_o  <= 1'b0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= '0;
      st_busy     <= 1'b0;
      st_match    <= 1'b0;
      st_dir      <= 1'b0;
      st_nack     <= 1'b0;
      st_underrun <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      rx_valid_o <= 1'b0;
      if (rx_pend) begin
        rx_pend    <= 1'b0;
        rx_data_o  <= shift_q;
        rx_valid_o <= 1'b1;
      end
      if (!en_i) begin
        state       <= S_IDLE;
        bit_cnt     <= '0;
        ack_q       <= 1'b0;
        rx_pend     <= 1'b0;
        sda_o       <= 1'b1;
        st_busy     <= 1'b0;
        st_match    <= 1'b0;
        st_dir      <= 1'b0;
        st_nack     <= 1'b0;
        st_underrun <= 1'b0;
      end else if (start_det) begin
        state       <= S_ADDR;
        bit_cnt     <= '0;
        ack_q       <= 1'b0;
        sda_o       <= 1'b1;
        st_busy     <= 1'b1;
        st_match    <= 1'b0;
        st_dir      <= 1'b0;
        st_nack     <= 1'b0;
        st_underrun <= 1'b0;
      end else if (stop_det) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        ack_q   <= 1'b0;
        sda_o   <= 1'b1;
        st_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sda_o <= 1'b1;
          end
          S_ADDR: begin
            if (scl_rise) begin
              shift_q <= {shift_q[DATA_WIDTH-2:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                if (shift_q[ADDR_WIDTH-1:0] == self_addr_i) begin
                  state    <= S_ADDR_ACK;
                  st_match <= 1'b1;
                  st_dir   <= sda_s;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_o <= 1'b0;
                ack_q <= 1'b1;
              end else begin
                ack_q   <= 1'b0;
                bit_cnt <= '0;
                if (st_dir) begin
                  state      <= S_TX_DATA;
                  sda_o      <= load_byte[DATA_WIDTH-1];
                  tx_shift   <= load_byte << 1;
                  tx_ready_o <= tx_valid_i;
                  if (!tx_valid_i) st_underrun <= 1'b1;
                end else begin
                  state <= S_RX_DATA;
                  sda_o <= 1'b1;
                end
              end
            end
          end
          S_RX_DATA: begin
            if (scl_rise) begin
              shift_q <= {shift_q[DATA_WIDTH-2:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                rx_pend <= 1'b1;
                state   <= S_RX_ACK;
              end
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_o <= 1'b0;
                ack_q <= 1'b1;
              end else begin
                ack_q   <= 1'b0;
                bit_cnt <= '0;
                sda_o   <= 1'b1;
                state   <= S_RX_DATA;
              end
            end
          end
          S_TX_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == BYTE_BITS) begin
                sda_o <= 1'b1;
                state <= S_TX_ACK;
              end else begin
                sda_o    <= tx_shift[DATA_WIDTH-1];
                tx_shift <= tx_shift << 1;
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                st_nack <= 1'b1;
                sda_o   <= 1'b1;
                state   <= S_IDLE;
              end else begin
                ack_q <= 1'b1;
              end
            end else if (scl_fall && ack_q) begin
              ack_q      <= 1'b0;
              bit_cnt    <= '0;
              state      <= S_TX_DATA;
              sda_o      <= load_byte[DATA_WIDTH-1];
              tx_shift   <= load_byte << 1;
              tx_ready_o <= tx_valid_i;
              if (!tx_valid_i) st_underrun <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            sda_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
